// File: rtl/frame_tx_pkg.sv
// Shared types and frame constants for the frame transmit sequencer.
// Optional feature macro: FRAME_REPEAT_EN (back-to-back repeat frames).
package frame_tx_pkg;

  localparam int FRAME_LEN_DEF = 19;
  localparam int PAYLOAD_W_DEF = 5;
  localparam int DIV_W_DEF     = 8;

  localparam logic [4:0] FRAME_HDR = 5'b11110;
  localparam logic [6:0] FRAME_TRL = 7'b0101111;
  // Tail stages between trailer and register end sit at idle level.
  localparam logic [1:0] FRAME_PAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    END
  } state_e;

  function automatic logic [FRAME_LEN_DEF-1:0] frame_word(
    input logic [PAYLOAD_W_DEF-1:0] p
  );
    return {FRAME_HDR, p, FRAME_TRL, FRAME_PAD};
  endfunction

endpackage

// File: rtl/frame_tx_sequencer_bit_tick_gen.sv
// Bit-period divider: counts 0..div-1 while run is high.
// tick is high on the terminal count of each period.
module bit_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = run && (cnt_q == (div - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_tx_sequencer.sv
// Load/shift sequencer for the frame register and idle-line mux.
// Optional feature macro: FRAME_REPEAT_EN adds repeat_i input.
module frame_tx_sequencer
  import frame_tx_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int DIV_W     = DIV_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic [DIV_W-1:0]     baud_div,
  output logic                 load_n,
  output logic                 shift_en,
  output logic                 tx_gate,
  output logic [PAYLOAD_W-1:0] payload_q,
  output logic                 busy,
  output logic                 done
`ifdef FRAME_REPEAT_EN
  ,
  input  logic                 repeat_i
`endif
);

  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic             tick;
  logic             rep_d;

`ifdef FRAME_REPEAT_EN
  logic             rep_q;
  assign rep_d = repeat_i;
`else
  assign rep_d = 1'b0;
`endif

  bit_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q == SHIFT),
    .div  (div_q),
    .tick (tick)
  );

  assign start_ready = (state_q == IDLE);

  // Last bit gets no shift so it holds for a full period.
  assign shift_en = (state_q == LOAD)
                  | (tick && (bit_q != LAST_BIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      payload_q <= '0;
      load_n    <= 1'b1;
      tx_gate   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FRAME_REPEAT_EN
      rep_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q   <= LOAD;
            payload_q <= payload;
            div_q     <= (baud_div == '0) ? DIV_W'(1) : baud_div;
            load_n    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          load_n  <= 1'b1;
          tx_gate <= 1'b1;
          bit_q   <= '0;
        end
        SHIFT: begin
          if (tick) begin
            if (bit_q == LAST_BIT) begin
              state_q <= END;
              tx_gate <= 1'b0;
              done    <= 1'b1;
              busy    <= rep_d;
`ifdef FRAME_REPEAT_EN
              rep_q   <= repeat_i;
`endif
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        END: begin
          done <= 1'b0;
`ifdef FRAME_REPEAT_EN
          if (rep_q) begin
            state_q <= LOAD;
            load_n  <= 1'b0;
            busy    <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy    <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Self-checking bench for frame_tx_sequencer with a cycle-index model
// and an emulated 19-stage frame register driving the line.
module tb_frame_tx_sequencer;
  import frame_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_valid = 1'b0;
  logic       repeat_i = 1'b0;
  logic [4:0] payload = '0;
  logic [7:0] baud_div = '0;
  logic       start_ready, load_n, shift_en, tx_gate, busy, done;
  logic [4:0] payload_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_tx_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .payload    (payload),
    .baud_div   (baud_div),
    .load_n     (load_n),
    .shift_en   (shift_en),
    .tx_gate    (tx_gate),
    .payload_q  (payload_q),
    .busy       (busy),
    .done       (done)
`ifdef FRAME_REPEAT_EN
    ,
    .repeat_i   (repeat_i)
`endif
  );

  // Emulated frame register and output mux
  logic [18:0] freg = '1;
  logic        line;
  always @(posedge clk) begin
    if (shift_en) begin
      if (!load_n) freg <= frame_word(payload_q);
      else         freg <= {freg[17:0], 1'b1};
    end
  end
  assign line = tx_gate ? freg[18] : 1'b1;

  function automatic logic [18:0] exp_frame(input logic [4:0] p);
    return {5'b11110, p, 7'b0101111, 2'b11};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: mt = cycles since LOAD (-1 when idle)
  int         mt = -1;
  int         md = 1;
  logic [4:0] mp = '0;
  logic       mrep = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mt   <= -1;
      md   <= 1;
      mp   <= '0;
      mrep <= 1'b0;
    end else if (mt < 0) begin
      if (start_valid) begin
        mt   <= 0;
        mp   <= payload;
        md   <= (baud_div == 0) ? 1 : int'(baud_div);
        mrep <= 1'b0;
      end
    end else if (mt == 19 * md + 1) begin
      mt <= mrep ? 0 : -1;
    end else begin
      if (mt == 19 * md) mrep <= repeat_i;
      mt <= mt + 1;
    end
  end

  always @(negedge clk) begin
    logic        e_gt, e_line;
    logic [18:0] ef;
    int          idx;
    if (rst_n) begin
      ef     = exp_frame(mp);
      e_gt   = (mt >= 1) && (mt <= 19 * md);
      e_line = 1'b1;
      if (e_gt) begin
        idx    = 18 - (mt - 1) / md;
        e_line = ef[idx];
      end
      chk("cmp_load_n", load_n, !(mt == 0));
      chk("cmp_shift_en", shift_en, (mt == 0) ||
          (mt >= 1 && mt <= 18 * md && (mt % md) == 0));
      chk("cmp_tx_gate", tx_gate, e_gt);
      chk("cmp_busy", busy, (mt >= 0) && (mt <= 19 * md || mrep));
      chk("cmp_done", done, mt == 19 * md + 1);
      chk("cmp_start_ready", start_ready, mt < 0);
      chk("cmp_payload_q", payload_q, mp);
      chk("cmp_line", line, e_line);
    end
  end

  task automatic request(input logic [4:0] p, input logic [7:0] d);
    start_valid = 1'b1;
    payload     = p;
    baud_div    = d;
  endtask

  task automatic wait_accept(output bit ok);
    int n = 0;
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = start_ready;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // Starts at the LOAD-cycle negedge, returns at the done cycle
  task automatic measure(input int de, output int tdone, output int nld,
                         output int nsh, output int ngate, output int nbusy,
                         output logic [18:0] bits);
    int c = 0;
    tdone = -1; nld = 0; nsh = 0; ngate = 0; nbusy = 0; bits = '0;
    while (c < 3000) begin
      if (!load_n) nld++;
      if (shift_en && tx_gate) nsh++;
      if (tx_gate) ngate++;
      if (busy) nbusy++;
      if (tx_gate && ((c - 1) % de) == 0) bits = {bits[17:0], line};
      if (done) begin
        tdone = c;
        break;
      end
      @(negedge clk);
      c++;
    end
  endtask

  task automatic frame_test(input string name, input logic [4:0] p,
                            input logic [7:0] d, input bit hold,
                            input logic [18:0] ebits, input int etdone,
                            input int egate);
    bit          ok;
    int          tdone, nld, nsh, ngate, nbusy;
    logic [18:0] bits;
    request(p, d);
    wait_accept(ok);
    chk({name, "_accept"}, ok, 1'b1);
    @(negedge clk);
    if (!hold) start_valid = 1'b0;
    measure((d == 0) ? 1 : int'(d), tdone, nld, nsh, ngate, nbusy, bits);
    chk({name, "_tdone"}, tdone, etdone);
    chk({name, "_nload"}, nld, 1);
    chk({name, "_nshift"}, nsh, 18);
    chk({name, "_ngate"}, ngate, egate);
    chk({name, "_nbusy"}, nbusy, etdone);
    chk({name, "_bits"}, bits, ebits);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_n", load_n, 1'b1);
    chk("rst_shift_en", shift_en, 1'b0);
    chk("rst_tx_gate", tx_gate, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_payload_q", payload_q, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_ready", start_ready, 1'b1);
      chk("idle_gate", tx_gate, 1'b0);
    end

    frame_test("d1", 5'b10110, 8'd1, 1'b0,
               19'b1111010110010111111, 20, 19);
    @(negedge clk);
    frame_test("d4", 5'b01001, 8'd4, 1'b0,
               19'b1111001001010111111, 77, 76);
    @(negedge clk);

    // baud_div 0 with start_valid held through the frame
    frame_test("d0", 5'b10110, 8'd0, 1'b1,
               19'b1111010110010111111, 20, 19);
    chk("hold_end_ready", start_ready, 1'b0);
    @(negedge clk);
    chk("hold_idle_ready", start_ready, 1'b1);
    @(negedge clk);
    chk("hold_reaccept", load_n, 1'b0);
    start_valid = 1'b0;
    wait_done("hold_second_done");
    @(negedge clk);

    // Asynchronous reset during bit 7
    begin
      bit ok;
      request(5'b01101, 8'd2);
      wait_accept(ok);
      chk("abort_accept", ok, 1'b1);
      @(negedge clk);
      start_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_bit7_gate", tx_gate, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_gate", tx_gate, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_shift", shift_en, 1'b0);
      chk("abort_load_n", load_n, 1'b1);
      chk("abort_payload", payload_q, 5'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_no_done", done, 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
    end
    frame_test("d3", 5'b00111, 8'd3, 1'b0,
               19'b1111000111010111111, 58, 57);
    @(negedge clk);

`ifdef FRAME_REPEAT_EN
    begin
      bit ok;
      int ndone = 0, nlow = 0, nrdy = 0, c = 0;
      repeat_i = 1'b1;
      request(5'b11001, 8'd2);
      wait_accept(ok);
      chk("rep_accept", ok, 1'b1);
      @(negedge clk);
      start_valid = 1'b0;
      while (c < 1000) begin
        if (done) ndone++;
        if (!busy) nlow++;
        if (start_ready) nrdy++;
        if (ndone == 3) break;
        if (ndone == 2) repeat_i = 1'b0;
        @(negedge clk);
        c++;
      end
      chk("rep_ndone", ndone, 3);
      chk("rep_busy_gaps", nlow, 0);
      chk("rep_ready_early", nrdy, 0);
      @(negedge clk);
      chk("rep_ready_after", start_ready, 1'b1);
    end
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
